reg_file_128x16: RTL and testbench
==================================

Name: reg_file_128x16

Overview:
- 128-entry x 16-bit register file with one write port and one asynchronous read port.
- Write port takes a 9-bit command/address word: a 2-bit write mode plus a 7-bit register index.
- Serves as the general-purpose register storage of the datapath; the read port feeds operand muxes combinationally.

Parameters:
- DATA_W, 16, register width in bits (must be even; byte lanes = DATA_W/2).
- ADDR_W, 7, register index width; DEPTH = 2**ADDR_W = 128.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Data_In  input  DATA_W  write data.
- Addr_In  input  ADDR_W+2  write command: [8:7] = write mode, [6:0] = write index.
- Addr_Out  input  ADDR_W  read index.
- Data_Out  output  DATA_W  contents of register Addr_Out.

Behaviour:
- Reset: rst high clears all 128 registers to 16'h0000 immediately, without waiting for clk. Data_Out therefore reads 0 during and after reset until a write occurs. rst has priority over any write on the same edge.
- Write modes, decoded from Addr_In[8:7], applied on each rising clk edge when rst is low:
  - 00: write full word, reg[idx] <= Data_In.
  - 01: write low byte only, reg[idx][7:0] <= Data_In[7:0]; upper byte is kept.
  - 10: write high byte only, reg[idx][15:8] <= Data_In[15:8]; lower byte is kept.
  - 11: no write (idle).
- There is no separate write-enable port. Addr_In = 0 with mode 00 writes register 0 on every edge, so the driver must hold mode 11 to idle.
- Read: Data_Out = reg[Addr_Out], combinational from the storage array with zero cycles of latency. Data_Out changes immediately when Addr_Out changes.
- Write-then-read: a value written on edge N appears on Data_Out just after edge N (combinational from the updated register).
- Same-address read/write in the same cycle: before the edge Data_Out shows the old value; after the edge it shows the new value (default build, no bypass).
- All indices 0..127 are valid. There is no wrap-around and no out-of-range condition, and no register is hard-wired.
- Writes to one index never disturb any other index.
- Reset asserted mid-operation clears everything asynchronously; the pending write is discarded.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: when a write is active (mode != 11) and Addr_In[6:0] == Addr_Out, Data_Out combinationally shows the post-write value before the edge.
  - Mode 00: Data_In.
  - Modes 01/10: merged bytes (written byte from Data_In, other byte from storage).
  - Reset still forces Data_Out to 0.
- Undefined: plain array read as described under Behaviour.

Decomposition:
- Shared package reg_file_pkg:
  - DATA_W and ADDR_W constants.
  - 2-bit write-mode type with named constants WR_FULL=00, WR_LO=01, WR_HI=10, WR_NONE=11.
  - Function that splits the 9-bit command word into mode and index.
- One natural sub-module, reg_word: a single DATA_W register with async reset and two byte-lane enables. It is instantiated 128 times behind the index/mode decoder; the read mux lives in the top module.

Test Plan:
- Basic writes and reads: reset; then, mode 00, write 1->idx0, 2->idx1, 3->idx2, 7->idx32.
  - Addr_Out=1 -> 2; Addr_Out=0 -> 1; Addr_Out=2 -> 3; Addr_Out=32 -> 7.
- Idle hold: Addr_In=9'h180|idx 33 (mode 11), Data_In=16'hDEAD for 3 edges -> idx33 still reads 0 and idx0 still reads 1.
- Byte lanes:
  - Write 16'h1234 full to idx5.
  - Mode 01 with Data_In=16'hFFAB -> idx5 reads 16'h12AB.
  - Mode 10 with Data_In=16'hCDFF -> idx5 reads 16'hCDAB.
- Async reset mid-run: after the writes above, pulse rst between edges -> Data_Out goes to 0 immediately; idx0, idx32 and idx127 all read 0 afterwards.
- Same-address collision: idx10 holds 16'h0001; drive a full write of 16'h0BEE to idx10 with Addr_Out=10.
  - Default build: reads 16'h0001 before the edge, 16'h0BEE after.
  - With REG_FILE_BYPASS_EN: reads 16'h0BEE before the edge.
- Address extremes and isolation:
  - Write 16'hAAAA->idx0 and 16'h5555->idx127 -> each reads back correctly.
  - Sweep all 128 with data=idx -> every index reads its own value.

Source files
------------

// File: rtl/reg_file_128x16_pkg.sv
// Shared constants, write-mode type and command decode for the 128x16 register file.
package reg_file_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned LANE_W = DATA_W / 2;
   localparam int unsigned CMD_W  = ADDR_W + 2;

   typedef enum logic [1:0] {
      WR_FULL = 2'b00,
      WR_LO   = 2'b01,
      WR_HI   = 2'b10,
      WR_NONE = 2'b11
   } wr_mode_e;

   typedef struct packed {
      wr_mode_e            mode;
      logic [ADDR_W-1:0]   idx;
   } wr_cmd_t;

   // Split the command word into write mode (upper two bits) and register index.
   function automatic wr_cmd_t split_cmd(input logic [CMD_W-1:0] cmd);
      wr_cmd_t r;
      r.mode = wr_mode_e'(cmd[CMD_W-1 -: 2]);
      r.idx  = cmd[ADDR_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/reg_file_128x16_if.sv
// Write-command / read-index bus of the register file.
interface reg_file_128x16_if;
   import reg_file_pkg::*;

   logic [DATA_W-1:0] Data_In;
   logic [CMD_W-1:0]  Addr_In;
   logic [ADDR_W-1:0] Addr_Out;
   logic [DATA_W-1:0] Data_Out;

   modport master (output Data_In, output Addr_In, output Addr_Out, input  Data_Out);
   modport slave  (input  Data_In, input  Addr_In, input  Addr_Out, output Data_Out);

endinterface

// File: rtl/reg_file_128x16_reg_word.sv
// One DATA_W register with async reset and independent low/high byte-lane enables.
module reg_word
   import reg_file_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we_lo,
   input  logic              i_we_hi,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);

   logic [DATA_W-1:0] r_q;

   // Byte-lane update; reset clears the word immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         if (i_we_lo) r_q[LANE_W-1:0]      <= i_d[LANE_W-1:0];
         if (i_we_hi) r_q[DATA_W-1:LANE_W] <= i_d[DATA_W-1:LANE_W];
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg_file_128x16.sv
// 128x16 register file: one byte-lane write port, one asynchronous read port.
// Optional macro REG_FILE_BYPASS_EN forwards a same-index write to Data_Out before the edge.
module reg_file_128x16
   import reg_file_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   reg_file_128x16_if.slave    bus
);

   wr_cmd_t           w_cmd;
   logic [DEPTH-1:0]  w_we_lo;
   logic [DEPTH-1:0]  w_we_hi;
   logic [DATA_W-1:0] w_q [DEPTH];
   logic [DATA_W-1:0] w_rd;

   assign w_cmd = split_cmd(bus.Addr_In);

   // Index/mode decode into per-word byte-lane enables.
   always_comb begin
      w_we_lo = '0;
      w_we_hi = '0;
      if ((w_cmd.mode == WR_FULL) || (w_cmd.mode == WR_LO)) w_we_lo[w_cmd.idx] = 1'b1;
      if ((w_cmd.mode == WR_FULL) || (w_cmd.mode == WR_HI)) w_we_hi[w_cmd.idx] = 1'b1;
   end

   for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
      reg_word u_word (
         .clk     (clk),
         .rst     (rst),
         .i_we_lo (w_we_lo[i]),
         .i_we_hi (w_we_hi[i]),
         .i_d     (bus.Data_In),
         .o_q     (w_q[i])
      );
   end

   assign w_rd = w_q[bus.Addr_Out];

`ifdef REG_FILE_BYPASS_EN
   logic [DATA_W-1:0] w_merged;

   // Forward the post-write value when the write index matches the read index.
   always_comb begin
      w_merged = w_rd;
      if (w_we_lo[bus.Addr_Out]) w_merged[LANE_W-1:0]      = bus.Data_In[LANE_W-1:0];
      if (w_we_hi[bus.Addr_Out]) w_merged[DATA_W-1:LANE_W] = bus.Data_In[DATA_W-1:LANE_W];
      if (rst)                   w_merged = '0;
   end

   assign bus.Data_Out = w_merged;
`else
   assign bus.Data_Out = w_rd;
`endif

endmodule

// File: tb/tb_reg_file_128x16.sv
// Directed self-checking bench for reg_file_128x16.
module tb_reg_file_128x16;
   import reg_file_pkg::*;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   reg_file_128x16_if u_if ();

   reg_file_128x16 u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [CMD_W-1:0] IDLE = 9'h1FF;

   task automatic chk(input string tag, input logic [DATA_W-1:0] exp);
      #1;
      n_chk++;
      assert (u_if.Data_Out === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, u_if.Data_Out, exp);
      end
   endtask

   task automatic rd(input string tag, input int idx, input logic [DATA_W-1:0] exp);
      u_if.Addr_Out = ADDR_W'(idx);
      chk(tag, exp);
   endtask

   // Drive one command for one rising edge, then return to idle just after it.
   task automatic wr(input logic [1:0] mode, input int idx, input logic [DATA_W-1:0] d);
      u_if.Addr_In = {mode, ADDR_W'(idx)};
      u_if.Data_In = d;
      @(posedge clk);
      #1;
      u_if.Addr_In = IDLE;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst          = 1'b1;
      u_if.Addr_In  = IDLE;
      u_if.Data_In  = '0;
      u_if.Addr_Out = '0;
      repeat (2) @(posedge clk);
      #1;
      rd("reset_idx0", 0, 16'h0000);
      rd("reset_idx127", 127, 16'h0000);
      rst = 1'b0;

      // Basic full-word writes
      wr(2'b00, 0, 16'd1);
      wr(2'b00, 1, 16'd2);
      wr(2'b00, 2, 16'd3);
      wr(2'b00, 32, 16'd7);
      rd("basic_idx1", 1, 16'd2);
      rd("basic_idx0", 0, 16'd1);
      rd("basic_idx2", 2, 16'd3);
      rd("basic_idx32", 32, 16'd7);

      // Idle mode holds everything
      u_if.Addr_In = 9'h180 | 9'd33;
      u_if.Data_In = 16'hDEAD;
      repeat (3) @(posedge clk);
      #1;
      u_if.Addr_In = IDLE;
      rd("idle_idx33", 33, 16'h0000);
      rd("idle_idx0", 0, 16'd1);

      // Byte lanes
      wr(2'b00, 5, 16'h1234);
      rd("lane_full", 5, 16'h1234);
      wr(2'b01, 5, 16'hFFAB);
      rd("lane_lo", 5, 16'h12AB);
      wr(2'b10, 5, 16'hCDFF);
      rd("lane_hi", 5, 16'hCDAB);

      // Async reset between edges, with a pending write discarded
      u_if.Addr_Out = 7'd5;
      rst = 1'b1;
      chk("arst_immediate", 16'h0000);
      u_if.Addr_In = {2'b00, 7'd0};
      u_if.Data_In = 16'hBEEF;
      @(posedge clk);
      #1;
      u_if.Addr_In = IDLE;
      rst = 1'b0;
      rd("arst_idx0", 0, 16'h0000);
      rd("arst_idx32", 32, 16'h0000);
      rd("arst_idx127", 127, 16'h0000);

      // Same-address collision
      wr(2'b00, 10, 16'h0001);
      u_if.Addr_Out = 7'd10;
      u_if.Addr_In  = {2'b00, 7'd10};
      u_if.Data_In  = 16'h0BEE;
`ifdef REG_FILE_BYPASS_EN
      chk("collide_before", 16'h0BEE);
`else
      chk("collide_before", 16'h0001);
`endif
      @(posedge clk);
      #1;
      u_if.Addr_In = IDLE;
      chk("collide_after", 16'h0BEE);

      // Address extremes
      wr(2'b00, 0, 16'hAAAA);
      wr(2'b00, 127, 16'h5555);
      rd("ext_idx0", 0, 16'hAAAA);
      rd("ext_idx127", 127, 16'h5555);

      // Full sweep: every index holds its own number
      for (int i = 0; i < 128; i++) wr(2'b00, i, 16'(i));
      for (int i = 0; i < 128; i++) rd($sformatf("sweep_idx%0d", i), i, 16'(i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
